// File: rtl/alu_cmd_pipe.sv
// alu_cmd_pipe: valid/ready command FIFO feeding an external 4-bit ALU, with a registered result stage
//   in_*  : command input (valid/ready), alu_* : FIFO head to ALU / ALU result back
//   out_* : registered result (valid/ready), fifo_count : queued entries, ops_done : accepted results
module alu_cmd_pipe #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_a,
  input  logic [3:0]               in_b,
  input  logic [2:0]               in_sel,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic [2:0]               alu_sel,
  input  logic [3:0]               alu_result,
  input  logic                     alu_carry,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_result,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic [2:0]               out_sel,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         ops_done
);
  localparam int AW = $clog2(DEPTH);
  logic [10:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ov_q, ov_d;
  logic [8:0]       pay_q, pay_d;
  logic [CNT_W-1:0] ops_q, ops_d;
  logic             push, adv;
  assign in_ready = cnt_q != (AW+1)'(DEPTH);
  assign push = in_valid && in_ready;
  assign adv = (cnt_q != '0) && (!ov_q || out_ready);
  assign {alu_a, alu_b, alu_sel} = (cnt_q == '0) ? 11'd0 : mem_q[rd_q];
  assign out_valid = ov_q;
  assign {out_result, out_carry, out_zero, out_sel} = pay_q;
  assign fifo_count = cnt_q;
  assign ops_done = ops_q;
  always_comb begin
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = adv ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(adv);
    ov_d = adv || (ov_q && !out_ready);
    pay_d = adv ? {alu_result, alu_carry, alu_result == 4'd0, alu_sel} : pay_q;
    ops_d = ops_q + CNT_W'(ov_q && out_ready);
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {in_a, in_b, in_sel};
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      ov_q <= 1'b0;
      pay_q <= '0;
      ops_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      ov_q <= ov_d;
      pay_q <= pay_d;
      ops_q <= ops_d;
    end
  end
endmodule

// File: tb/tb_alu_cmd_pipe.sv
// tb_alu_cmd_pipe: randomized + directed bench for alu_cmd_pipe against a queue-based model
module tb_alu_cmd_pipe;
  localparam int DEPTH = 4;
  localparam int CW = 4;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [3:0] in_a = 0, in_b = 0;
  logic [2:0] in_sel = 0;
  logic in_ready, alu_carry, out_valid, out_carry, out_zero;
  logic [3:0] alu_a, alu_b, alu_result, out_result;
  logic [2:0] alu_sel, out_sel;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CW-1:0] ops_done;
  typedef struct {logic [3:0] a; logic [3:0] b; logic [2:0] s;} cmd_t;
  cmd_t q[$];
  logic m_ov = 0, m_car = 0, m_zero = 0;
  logic [3:0] m_res = 0;
  logic [2:0] m_sel = 0;
  logic [CW-1:0] m_ops = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  alu_cmd_pipe #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_zero(out_zero), .out_sel(out_sel),
    .fifo_count(fifo_count), .ops_done(ops_done)
  );
  function automatic logic [4:0] alu_f(logic [3:0] a, logic [3:0] b, logic [2:0] s);
    case (s)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {1'b0, a} - {1'b0, b};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, ~a};
      3'd6: return {1'b0, a[2:0], 1'b0};
      default: return {2'b0, a[3:1]};
    endcase
  endfunction
  assign {alu_carry, alu_result} = alu_f(alu_a, alu_b, alu_sel);
  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic compare();
    cmd_t h;
    h = '{a: 4'd0, b: 4'd0, s: 3'd0};
    if (q.size() != 0) h = q[0];
    chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("alu_a", 32'(alu_a), 32'(h.a));
    chk("alu_b", 32'(alu_b), 32'(h.b));
    chk("alu_sel", 32'(alu_sel), 32'(h.s));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_result", 32'(out_result), 32'(m_res));
    chk("out_carry", 32'(out_carry), 32'(m_car));
    chk("out_zero", 32'(out_zero), 32'(m_zero));
    chk("out_sel", 32'(out_sel), 32'(m_sel));
    chk("ops_done", 32'(ops_done), 32'(m_ops));
  endtask
  task automatic step(logic v, logic [3:0] a, logic [3:0] b, logic [2:0] s, logic r, logic rs);
    logic adv;
    logic [4:0] y;
    cmd_t h;
    in_valid = v; in_a = a; in_b = b; in_sel = s; out_ready = r; rst = rs;
    if (rs) begin
      q.delete();
      m_ov = 0; m_res = 0; m_car = 0; m_zero = 0; m_sel = 0; m_ops = 0;
    end else begin
      adv = (q.size() != 0) && (!m_ov || r);
      if (m_ov && r) m_ops = m_ops + 1'b1;
      if (adv) begin
        h = q.pop_front();
        y = alu_f(h.a, h.b, h.s);
        m_res = y[3:0]; m_car = y[4]; m_zero = (y[3:0] == 4'd0); m_sel = h.s; m_ov = 1;
      end else if (m_ov && r) m_ov = 0;
      if (v && q.size() + (adv ? 1 : 0) != DEPTH) q.push_back('{a: a, b: b, s: s});
    end
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask
  initial begin
    logic [3:0] sa [5];
    logic [3:0] sb [5];
    logic [2:0] ss [5];
    logic [3:0] se [5];
    sa = '{4'hF, 4'h3, 4'hA, 4'h9, 4'h9};
    sb = '{4'h5, 4'h4, 4'hA, 4'h0, 4'h0};
    ss = '{3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    se = '{4'h5, 4'h7, 4'h0, 4'h2, 4'h4};
    step(0, 0, 0, 0, 1, 1);
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_out_valid", 32'(out_valid), 0);
    // single add 9+8
    step(1, 9, 8, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("add_valid", 32'(out_valid), 1);
    chk("add_result", 32'(out_result), 1);
    chk("add_carry", 32'(out_carry), 1);
    chk("add_zero", 32'(out_zero), 0);
    step(0, 0, 0, 0, 1, 0);
    chk("add_ops_done", 32'(ops_done), 1);
    // streaming
    for (int i = 0; i < 7; i++) begin
      if (i < 5) step(1, sa[i], sb[i], ss[i], 1, 0);
      else step(0, 0, 0, 0, 1, 0);
      chk("stream_in_ready", 32'(in_ready), 1);
      if (i >= 1 && i <= 5) chk("stream_result", 32'(out_result), 32'(se[i-1]));
      if (i == 3) chk("stream_zero", 32'(out_zero), 1);
    end
    // backpressure / full
    step(0, 0, 0, 0, 1, 1);
    for (int i = 1; i <= 6; i++) begin
      step(1, 4'(i), 0, 3, 0, 0);
      if (i >= 2) chk("bp_held", 32'(out_result), 1);
    end
    chk("bp_full_count", 32'(fifo_count), 4);
    chk("bp_full_ready", 32'(in_ready), 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 0);
      chk("bp_drain", 32'(out_result), 32'(i + 2));
    end
    step(0, 0, 0, 0, 1, 0);
    chk("bp_drained", 32'(out_valid), 0);
    // simultaneous push/pop at count 2, wrapping pointers
    step(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 4'(i), 4'(i), 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 4'(i + 5), 4'(i), 1, 1, 0);
      chk("simul_count", 32'(fifo_count), 2);
    end
    // reset mid-stream
    step(1, 7, 7, 4, 0, 0);
    chk("pre_reset_count", 32'(fifo_count), 3);
    step(0, 0, 0, 0, 0, 1);
    chk("mid_reset_valid", 32'(out_valid), 0);
    chk("mid_reset_count", 32'(fifo_count), 0);
    chk("mid_reset_ops", 32'(ops_done), 0);
    step(1, 2, 3, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("sub_result", 32'(out_result), 32'hF);
    chk("sub_carry", 32'(out_carry), 1);
    // counter wrap
    step(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 17; i++) step(1, 4'(i), 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    chk("ops_wrap", 32'(ops_done), 1);
    // randomized traffic with varying backpressure
    for (int i = 0; i < 2000; i++)
      step(($urandom % 4) != 0, 4'($urandom), 4'($urandom), 3'($urandom),
           ($urandom % ((i / 250) % 4 + 2)) != 0, ($urandom % 200) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_cmd_pipe.md
# alu_cmd_pipe

Command buffer and result capture stage wrapped around the 4-bit combinational ALU. Accepts ALU commands (operands plus 3-bit opcode) over a valid/ready interface and queues them in a small FIFO. It drives the FIFO head onto the ALU inputs, then registers the ALU result, carry and a zero flag into a valid/ready output stage. This turns the combinational ALU into a flow-controlled, one-op-per-cycle pipeline stage.

## Interface
- DEPTH, 4, command FIFO entries; power of two, 2..16
- CNT_W, 16, width of completed-operation counter
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  command present on in_a/in_b/in_sel
- in_ready  output  1  FIFO can accept a command this cycle
- in_a  input  4  operand A
- in_b  input  4  operand B
- in_sel  input  3  opcode (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 shl, 111 shr)
- alu_a  output  4  to ALU operand A (FIFO head)
- alu_b  output  4  to ALU operand B (FIFO head)
- alu_sel  output  3  to ALU opcode (FIFO head)
- alu_result  input  4  from ALU result
- alu_carry  input  1  from ALU carry
- out_valid  output  1  registered result valid
- out_ready  input  1  consumer accepts result
- out_result  output  4  registered result
- out_carry  output  1  registered carry
- out_zero  output  1  registered (out_result == 0)
- out_sel  output  3  opcode that produced out_result
- fifo_count  output  clog2(DEPTH)+1  entries currently queued
- ops_done  output  CNT_W  results accepted downstream, wraps modulo 2^CNT_W

## Operation
- FIFO: circular buffer, wr_ptr/rd_ptr of clog2(DEPTH) bits wrapping at DEPTH, plus count register.
- in_ready = (count != DEPTH). Push when in_valid && in_ready. No push-while-full, even if a pop occurs in the same cycle.
- alu_a/alu_b/alu_sel = FIFO head entry at rd_ptr. When the FIFO is empty they drive 0/0/000.
- Output stage is one register, out_valid plus payload.
- advance = (count != 0) && (!out_valid || out_ready).
- On advance: pop head. Load out_result <= alu_result, out_carry <= alu_carry, out_zero <= (alu_result == 4'b0), out_sel <= alu_sel. Set out_valid <= 1.
- Else if out_valid && out_ready: out_valid <= 0. The payload holds its last value.
- While out_valid && !out_ready, the payload is stable and no pop occurs.
- Simultaneous push and pop: count unchanged, both pointers advance. When count is 0, push and advance cannot coincide because the head is not yet valid.
- ops_done increments by 1 on each cycle with out_valid && out_ready.
- fifo_count = count.
- The block does not interpret the opcode; carry semantics are whatever the ALU returns. For the 4-bit ALU this means: add gives carry-out, sub gives the borrow bit of the 5-bit difference, and logic/shift ops give carry 0.

## Timing
- Reset (rst high at a clock edge) forces:
  - count=0, wr_ptr=0, rd_ptr=0, ops_done=0
  - out_valid=0, out_result=0, out_carry=0, out_zero=0, out_sel=0
  - FIFO storage contents are don't-care.
- After the reset edge: in_ready=1, alu_* outputs=0.
- Reset mid-operation drops all queued commands and any pending result. No result from before reset may appear afterwards.
- Latency: a command accepted at edge N sits at the FIFO head during cycle N+1. With the output free it is captured at edge N+1, so out_valid is high during cycle N+2. Minimum latency is 2 cycles.
- Throughput: 1 command/cycle with out_ready held high.
- in_ready depends only on registered count; it has no combinational path from in_valid.
- advance depends combinationally on out_ready. This is the only in-to-out combinational path besides the alu_* to alu_result loop through the external ALU.
- Full condition: with out_ready low, DEPTH accepts plus 1 captured result fill the block. It holds DEPTH+1 commands in total.

## Test plan
- Reset then single add: in_a=9, in_b=8, in_sel=000, out_ready=1 → 2 cycles later out_valid=1, out_result=0001, out_carry=1, out_zero=0, out_sel=000; ops_done=1 the following cycle.
- Streaming: push and(F,5), or(3,4), xor(A,A), shl(9), shr(9) back-to-back, out_ready=1 → results 5, 7, 0 (out_zero=1), 2, 4 on consecutive cycles in order; in_ready stays 1.
- Backpressure/full (DEPTH=4): out_ready=0, offer 6 commands → 5 accepted, in_ready=0 once fifo_count=4. The first result is held stable. Raising out_ready drains all 5 in order, one per cycle.
- Simultaneous push/pop at count=2 with out_ready=1 → fifo_count stays 2 and pointers wrap correctly past entry 3 to 0.
- Reset mid-stream: with 3 queued plus out_valid=1, assert rst for one edge → out_valid=0, fifo_count=0, ops_done=0. A new command sub(2,3) yields out_result=1111, out_carry=1.
- Counter wrap: with CNT_W=4, complete 17 operations → ops_done reads 1.
